// File: rtl/uart_boot_loader_if.sv
// Memory-bus link between the boot loader (initiator) and the UART responder.
// read_data is combinational from the responder in the same cycle as mem_read.
interface uart_boot_loader_if;
  logic [31:0] address;
  logic [31:0] write_data;
  logic        mem_write;
  logic        mem_read;
  logic [31:0] read_data;
  logic        wait_request;

  modport master (
    output address, write_data, mem_write, mem_read,
    input  read_data, wait_request
  );
  modport slave (
    input  address, write_data, mem_write, mem_read,
    output read_data, wait_request
  );
endinterface

// File: rtl/uart_boot_loader.sv
// UART boot loader: polls the UART, receives a length-prefixed LE word image,
// writes it into instruction memory and returns an 8-bit payload checksum.
module uart_boot_loader #(
  parameter logic [31:0] UART_BASE = 32'h1000_0000,
  parameter logic [31:0] LOAD_BASE = 32'h0000_0000,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  uart_boot_loader_if.master  bus,
  output logic                imem_we,
  output logic [31:0]         imem_addr,
  output logic [31:0]         imem_wdata,
  output logic                busy,
  output logic                done,
  output logic                error,
  output logic [15:0]         word_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_POLL, S_READ, S_CHECK, S_WRITE, S_ACK, S_DONE, S_ERROR
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  lane_q, lane_d;
  logic        hdr_q, hdr_d;
  logic [31:0] word_q, word_d;
  logic [15:0] len_q, len_d;
  logic [15:0] wcnt_q, wcnt_d;
  logic [7:0]  csum_q, csum_d;
  logic [7:0]  rx_byte;

  assign rx_byte = bus.read_data[7:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      hdr_q   <= 1'b0;
      word_q  <= '0;
      len_q   <= '0;
      wcnt_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      hdr_q   <= hdr_d;
      word_q  <= word_d;
      len_q   <= len_d;
      wcnt_q  <= wcnt_d;
      csum_q  <= csum_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    hdr_d   = hdr_q;
    word_d  = word_q;
    len_d   = len_q;
    wcnt_d  = wcnt_q;
    csum_d  = csum_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (start) begin
          state_d = S_POLL;
          lane_d  = '0;
          hdr_d   = 1'b1;
          word_d  = '0;
          len_d   = '0;
          wcnt_d  = '0;
          csum_d  = '0;
        end
      end
      S_POLL: if (!bus.read_data[0]) state_d = S_READ;
      S_READ: begin
        word_d[{lane_q, 3'b000} +: 8] = rx_byte;
        lane_d = lane_q + 2'd1;
        // Header bytes are not part of the checksum.
        if (!hdr_q) csum_d = csum_q + rx_byte;
        if (lane_q != 2'd3) state_d = S_POLL;
        else                state_d = hdr_q ? S_CHECK : S_WRITE;
      end
      S_CHECK: begin
        if (word_q == 32'd0 || word_q > 32'(MAX_WORDS)) begin
          state_d = S_ERROR;
        end else begin
          len_d   = word_q[15:0];
          hdr_d   = 1'b0;
          state_d = S_POLL;
        end
      end
      S_WRITE: begin
        if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        if ({1'b0, wcnt_q} + 17'd1 >= {1'b0, len_q}) state_d = S_ACK;
        else                                         state_d = S_POLL;
      end
      S_ACK: if (!bus.wait_request) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  // Moore outputs: everything below depends on registered state only.
  always_comb begin
    bus.address    = '0;
    bus.write_data = '0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    imem_we        = 1'b0;
    imem_addr      = '0;
    imem_wdata     = '0;
    case (state_q)
      S_POLL: begin
        bus.mem_read = 1'b1;
        bus.address  = UART_BASE + 32'd4;
      end
      S_READ: begin
        bus.mem_read = 1'b1;
        bus.address  = UART_BASE;
      end
      S_WRITE: begin
        imem_we    = 1'b1;
        imem_addr  = LOAD_BASE + {14'b0, wcnt_q, 2'b00};
        imem_wdata = word_q;
      end
      S_ACK: begin
        bus.mem_write  = 1'b1;
        bus.address    = UART_BASE;
        bus.write_data = {24'b0, csum_q};
      end
      default: ;
    endcase
  end

  assign busy       = (state_q != S_IDLE) && (state_q != S_DONE) && (state_q != S_ERROR);
  assign done       = (state_q == S_DONE);
  assign error      = (state_q == S_ERROR);
  assign word_count = wcnt_q;

endmodule

// File: doc/uart_boot_loader.md
# uart_boot_loader

Bus-initiator boot loader for the single-cycle RISC-V system. After a start pulse it takes over the memory bus, polls the memory-mapped UART, and receives a length-prefixed program image as little-endian 32-bit words. It writes each word into instruction memory through a dedicated write port, then returns an 8-bit checksum byte to the host through the UART TX register. It is the initiator that drives the UART responder's bus port; the CPU is held off the bus while `busy` is high.

## Interface
- `UART_BASE`, 32'h10000000, base address of the UART register window (data at +0, status at +4)
- `LOAD_BASE`, 32'h00000000, instruction-memory byte address of the first loaded word
- `MAX_WORDS`, 1024, largest accepted image length in words
- `clk`  in  1  single system clock, rising edge
- `reset`  in  1  asynchronous, active-high reset
- `start`  in  1  one-cycle pulse; begins a load when not busy
- `address`  out  32  bus address to the UART
- `write_data`  out  32  bus write data; only bits 7:0 are meaningful
- `mem_write`  out  1  bus write strobe
- `mem_read`  out  1  bus read strobe; a read at +0 pops one RX byte
- `read_data`  in  32  bus read data, valid in the same cycle as `mem_read`
- `wait_request`  in  1  high means the write must be held (TX full)
- `imem_we`  out  1  instruction-memory write enable
- `imem_addr`  out  32  instruction-memory byte address
- `imem_wdata`  out  32  instruction-memory write word
- `busy`  out  1  high from the cycle after an accepted `start` until DONE or ERROR
- `done`  out  1  sticky high after a successful load
- `error`  out  1  sticky high after a rejected length
- `word_count`  out  16  number of payload words written so far

## Operation
- Image format: 4 header bytes holding the length N in words (little-endian), followed by 4·N payload bytes, with the first byte going to bits 7:0 of each word.
- States: IDLE, POLL, READ, CHECK, WRITE, ACK, DONE, ERROR.
- IDLE / DONE / ERROR: `start`=1 clears `done`, `error`, `word_count`, the byte counter and the checksum, then goes to POLL. A `start` pulse in any other state is ignored.
- POLL: `mem_read`=1, `address`=UART_BASE+4. If `read_data[0]` (rx_empty) is 1, stay in POLL and re-issue the read every cycle. Otherwise go to READ.
- READ: `mem_read`=1, `address`=UART_BASE+0. Capture `read_data[7:0]` into the byte lane given by the byte counter (mod 4) and increment the counter.
  - Fewer than 4 bytes held: return to POLL.
  - Header word complete: go to CHECK.
  - Payload word complete: go to WRITE.
- CHECK: N=0 or N>MAX_WORDS goes to ERROR, with no imem write and no ACK. Otherwise latch N and go to POLL.
- WRITE: `imem_we`=1 for exactly one cycle, `imem_addr`=LOAD_BASE+4·word_count, `imem_wdata`=assembled word. Increment `word_count`. If `word_count` reaches N, go to ACK; otherwise go to POLL.
- ACK: `mem_write`=1, `address`=UART_BASE+0, `write_data`={24'b0, checksum}. Hold all three unchanged while `wait_request`=1. Go to DONE in the first cycle with `wait_request`=0.
- Checksum: 8-bit sum, modulo 256, of payload bytes only; header bytes are excluded.
- Address arithmetic is 32-bit and wraps. `word_count` saturates at its width; MAX_WORDS ≤ 65535.
- Bus strobes are never active in IDLE, CHECK, WRITE, DONE or ERROR. `mem_read` and `mem_write` are never high together.

## Timing
- Reset values: all outputs 0; state IDLE; internal counters and checksum 0.
- Reset asserted mid-load returns to IDLE asynchronously. Strobes drop immediately, no partial word is written, and `done`/`error` stay 0.
- `start` sampled in cycle t gives POLL in cycle t+1, with `busy`=1 from t+1.
- Minimum 2 cycles per byte (POLL+READ) when the RX FIFO is non-empty.
- Minimum 9 cycles per payload word (4×(POLL+READ) + WRITE).
- `done` or `error` rises the same cycle `busy` falls.
- All outputs are decoded from registered state (Moore). Inputs affect outputs only through the next state.

## Test plan
- Bytes 02 00 00 00 44 33 22 11 DD CC BB AA supplied back-to-back -> imem writes (0x00000000, 0x11223344) then (0x00000004, 0xAABBCCDD); ACK `write_data`=0x000000B8; `done`=1, `word_count`=2.
- Same image with rx_empty=1 for 5 cycles between every byte -> identical writes and checksum; POLL repeats while empty; no extra pops.
- Header 00 00 00 00, and separately N=1025 -> `error`=1, `busy`=0, no `imem_we`, no `mem_write`.
- `wait_request` held high 7 cycles during ACK -> address, data and `mem_write` stable for 8 cycles; DONE follows the release cycle.
- `reset` pulsed after the 6th byte, then `start` and a full N=1 image -> only the second load's word is written; outputs 0 during reset.
- `start` pulsed mid-payload -> ignored; load completes normally; a second `start` from DONE clears `done` and reloads.
